// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: parameter defaults, FSM and
// PC-control encodings, and the IF/ID pipeline register layout.
// Ports: none (package only).
package instruction_fetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_op_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register with hold / increment-by-4 / load controls.
// Ports: clk_i, reset_i (sync, active high), op_i (hold/inc/load), load_val_i, pc_o.
// Increment wraps modulo 2^32; loads are word-aligned here so the PC is never misaligned.
module program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  pc_op_e      op_i,
    input  logic [31:0] load_val_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        case (op_i)
            PC_INC:  pc_d = pc_q + 32'd4;
            PC_LOAD: pc_d = word_align(load_val_i);
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives Address to async-read instruction memory and
// registers {Instruction, PC+4, Valid} into IF/ID (1-cycle latency).
// Ports: Clk, Reset (sync, active high), Address, Instruction, Stall, Redirect,
// RedirectTarget, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, Halted.
// Stall freezes PC and IF/ID; Redirect overrides Stall and halt and flushes IF/ID.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEF_HALT_WORD,
    parameter logic [31:0] NOP_WORD  = DEF_NOP_WORD
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Halted
);

    fetch_state_e state_q, state_d;
    if_id_t       if_id_q, if_id_d;
    pc_op_e       pc_op;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i      (Clk),
        .reset_i    (Reset),
        .op_i       (pc_op),
        .load_val_i (RedirectTarget),
        .pc_o       (pc)
    );

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        state_d = state_q;
        if_id_d = if_id_q;
        pc_op   = PC_HOLD;
        if (Redirect) begin
            // Redirect wins over Stall and the halt sentinel in every state.
            pc_op   = PC_LOAD;
            if_id_d = '{instr: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!Stall) begin
                        if_id_d = '{instr: Instruction, pc_plus4: pc_plus4, valid: 1'b1};
                        // The halt word itself retires downstream, but the PC parks on it.
                        if (Instruction == HALT_WORD) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_op = PC_INC;
                        end
                    end
                end
                ST_HALT: begin
                    if_id_d = '{instr: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            if_id_q <= '{instr: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};
        end else begin
            state_q <= state_d;
            if_id_q <= if_id_d;
        end
    end

    assign Address           = word_align(pc);
    assign IF_ID_Instruction = if_id_q.instr;
    assign IF_ID_PCPlus4     = if_id_q.pc_plus4;
    assign IF_ID_Valid       = if_id_q.valid;
    assign Halted            = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        Halted;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction memory: word i holds i*3, optional halt stub at one address.
    logic [31:0] mem [0:127];
    logic        halt_en;
    logic [31:0] halt_addr;
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'(i * 3);
    end
    assign Instruction = (halt_en && Address == halt_addr) ? 32'hFFFF_FFFF : mem[Address[8:2]];

    instruction_fetch_unit dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .Address           (Address),
        .Instruction       (Instruction),
        .Stall             (Stall),
        .Redirect          (Redirect),
        .RedirectTarget    (RedirectTarget),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .Halted            (Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the memory returns for a word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int unsigned idx;
        if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
        idx = (a / 4) % 128;
        return 32'(idx * 3);
    endfunction

    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_v, m_started, m_halted;
    logic        chk_en = 1'b0;

    always @(posedge Clk) begin
        logic [31:0] w;
        if (Reset) begin
            m_pc = 32'h0; m_started = 0; m_halted = 0;
            m_instr = 32'h0; m_p4 = 32'h0; m_v = 0;
        end else if (Redirect) begin
            m_pc = RedirectTarget & ~32'h3;
            m_instr = 32'h0; m_p4 = 32'h0; m_v = 0;
            m_started = 1; m_halted = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_halted) begin
            m_instr = 32'h0; m_v = 0;
        end else if (!Stall) begin
            w = mem_word(m_pc);
            m_instr = w; m_p4 = m_pc + 32'd4; m_v = 1;
            if (w == 32'hFFFF_FFFF) m_halted = 1;
            else m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("model_addr",  Address, m_pc);
            chk("model_instr", IF_ID_Instruction, m_instr);
            chk("model_valid", {31'h0, IF_ID_Valid}, {31'h0, m_v});
            chk("model_halt",  {31'h0, Halted}, {31'h0, m_halted});
            if (!(m_halted && !m_v)) chk("model_p4", IF_ID_PCPlus4, m_p4);
        end
    end

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] ins, input logic [31:0] p4,
                            input logic v);
        chk({name, "_instr"}, IF_ID_Instruction, ins);
        chk({name, "_p4"}, IF_ID_PCPlus4, p4);
        chk({name, "_valid"}, {31'h0, IF_ID_Valid}, {31'h0, v});
    endtask

    initial begin
        Reset = 1; Stall = 0; Redirect = 0; RedirectTarget = 32'h0;
        halt_en = 0; halt_addr = 32'h10;
        tick();
        chk_en = 1'b1;
        tick();
        // 1. reset values and IDLE cycle, then normal fetch
        chk("rst_addr", Address, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst_halted", {31'h0, Halted}, 32'h0);
        Reset = 0;
        tick();
        chk("idle_addr", Address, 32'h0);
        chk("idle_valid", {31'h0, IF_ID_Valid}, 32'h0);
        tick();
        chk("run1_addr", Address, 32'h4);
        chk_ifid("run1", 32'h0, 32'h4, 1'b1);
        tick();
        chk("run2_addr", Address, 32'h8);
        chk_ifid("run2", 32'h3, 32'h8, 1'b1);
        // 2. stall for 3 cycles at PC=0x8
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", Address, 32'h8);
            chk_ifid("stall", 32'h3, 32'h8, 1'b1);
        end
        Stall = 0;
        tick();
        chk_ifid("unstall", 32'h6, 32'hC, 1'b1);
        chk("unstall_addr", Address, 32'hC);
        // 3. redirect overrides stall, target alignment
        Stall = 1; Redirect = 1; RedirectTarget = 32'h43;
        tick();
        chk("redir_addr", Address, 32'h40);
        chk_ifid("redir", 32'h0, 32'h0, 1'b0);
        Stall = 0; Redirect = 0;
        tick();
        chk_ifid("redir_next", 32'h30, 32'h44, 1'b1);
        // 4. halt sentinel at 0x10
        halt_en = 1;
        Redirect = 1; RedirectTarget = 32'h8;
        tick();
        Redirect = 0;
        tick();
        tick();
        chk("pre_halt_addr", Address, 32'h10);
        tick();
        chk_ifid("halt_cap", 32'hFFFF_FFFF, 32'h14, 1'b1);
        chk("halt_cap_addr", Address, 32'h10);
        chk("halt_flag", {31'h0, Halted}, 32'h1);
        Stall = 1;
        tick();
        tick();
        chk("halt_hold_addr", Address, 32'h10);
        chk("halt_hold_valid", {31'h0, IF_ID_Valid}, 32'h0);
        chk("halt_hold_flag", {31'h0, Halted}, 32'h1);
        Stall = 0; Redirect = 1; RedirectTarget = 32'h0;
        tick();
        chk("unhalt_flag", {31'h0, Halted}, 32'h0);
        chk("unhalt_addr", Address, 32'h0);
        Redirect = 0;
        tick();
        chk_ifid("unhalt_run", 32'h0, 32'h4, 1'b1);
        halt_en = 0;
        // 5. PC wrap
        Redirect = 1; RedirectTarget = 32'hFFFF_FFFC;
        tick();
        Redirect = 0;
        tick();
        chk_ifid("wrap", 32'h17D, 32'h0, 1'b1);
        chk("wrap_addr", Address, 32'h0);
        // 6. reset mid-run with redirect
        Redirect = 1; RedirectTarget = 32'h20;
        tick();
        Redirect = 0;
        tick();
        chk("mid_addr", Address, 32'h24);
        Reset = 1; Redirect = 1; RedirectTarget = 32'h100;
        tick();
        chk("mrst_addr", Address, 32'h0);
        chk_ifid("mrst", 32'h0, 32'h0, 1'b0);
        chk("mrst_halted", {31'h0, Halted}, 32'h0);
        Reset = 0; Redirect = 0;
        tick();
        chk("mrst_idle_addr", Address, 32'h0);
        chk("mrst_idle_valid", {31'h0, IF_ID_Valid}, 32'h0);
        tick();
        chk("mrst_run_addr", Address, 32'h4);
        // Randomized phase, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            Reset = ($urandom_range(0, 199) == 0);
            Stall = ($urandom_range(0, 9) < 3);
            Redirect = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) RedirectTarget = $urandom;
            else RedirectTarget = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) begin
                halt_en = ~halt_en;
                halt_addr = 32'($urandom_range(0, 15)) << 2;
            end
            tick();
        end
        Reset = 0; Stall = 0; Redirect = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
